// File: rtl/median_window_pkg.sv
// median_pkg: shared definitions for the 3x3 median window front end and the
// median network it feeds.
//   DATA_WIDTH_DEFAULT : default pixel width in bits
//   COL_BUNDLE_W       : width of the nine sorted-column outputs (c1/c2/c3 h/m/l)
//                        taken together, as consumed by the median network
//   clog2()            : ceiling log2, used to size the column counter
package median_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int COL_BUNDLE_W       = 9 * DATA_WIDTH_DEFAULT;

  // Number of bits needed to address 'value' distinct locations.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/median_window_column_sorter.sv
// column_sorter: combinational 3-input sorting network.
// Ports:
//   a, b, c  in  DATA_WIDTH  unsorted column (top, middle, newest pixel)
//   hi       out DATA_WIDTH  largest of the three
//   mid      out DATA_WIDTH  median of the three
//   lo       out DATA_WIDTH  smallest of the three
// Three compare/swap stages: order (a,b), push the larger against c to get the
// maximum, then order the two remaining values for median and minimum.
module column_sorter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] mid,
  output logic [DATA_WIDTH-1:0] lo
);

  logic [DATA_WIDTH-1:0] abMin;
  logic [DATA_WIDTH-1:0] abMax;
  logic [DATA_WIDTH-1:0] restMax;

  always_comb begin
    abMin = (a > b) ? b : a;
    abMax = (a > b) ? a : b;

    // The larger of (a,b) against c yields the overall maximum; the loser
    // still has to be ranked against the smaller of (a,b).
    hi      = (abMax > c) ? abMax : c;
    restMax = (abMax > c) ? c : abMax;

    mid = (restMax > abMin) ? restMax : abMin;
    lo  = (restMax > abMin) ? abMin : restMax;
  end

endmodule

// File: rtl/median_window.sv
// median_window: streaming 3x3 window generator for the median filter.
// Accepts one raster-order pixel per pix_valid cycle, keeps the two previous
// lines in line buffers, sorts each vertical column of three pixels and shifts
// the last three sorted columns into registered outputs.
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   frame_start        synchronous start of frame, restarts row/column position
//   pix_valid/pix_data incoming pixel, raster order
//   c1h..c3l           sorted columns, c1 oldest, c3 newest (high/mid/low)
//   win_valid          one-cycle strobe, c1..c3 hold a complete 3x3 window
module median_window
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int IMG_WIDTH  = 640,
  parameter int ADDR_WIDTH = clog2(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic [DATA_WIDTH-1:0] c3h,
  output logic [DATA_WIDTH-1:0] c3m,
  output logic [DATA_WIDTH-1:0] c3l,
  output logic [DATA_WIDTH-1:0] c2h,
  output logic [DATA_WIDTH-1:0] c2m,
  output logic [DATA_WIDTH-1:0] c2l,
  output logic [DATA_WIDTH-1:0] c1h,
  output logic [DATA_WIDTH-1:0] c1m,
  output logic [DATA_WIDTH-1:0] c1l,
  output logic                  win_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [1:0]            ROW_FULL = 2'd2;

  logic [ADDR_WIDTH-1:0] colQ, colD;
  logic [1:0]            rowQ, rowD;
  logic [ADDR_WIDTH-1:0] procCol;
  logic [1:0]            procRow;

  logic [DATA_WIDTH-1:0] lbTop [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lbMid [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] topRd;
  logic [DATA_WIDTH-1:0] midRd;

  logic [DATA_WIDTH-1:0] sortHi, sortMid, sortLo;

  logic [DATA_WIDTH-1:0] c3hQ, c3mQ, c3lQ;
  logic [DATA_WIDTH-1:0] c2hQ, c2mQ, c2lQ;
  logic [DATA_WIDTH-1:0] c1hQ, c1mQ, c1lQ;
  logic                  winValidQ, winValidD;

  // A pixel arriving together with frame_start is treated as the first pixel
  // of the new frame, so every use of the position goes through procCol/procRow.
  always_comb begin
    procCol = frame_start ? '0 : colQ;
    procRow = frame_start ? '0 : rowQ;
  end

  assign topRd = lbTop[procCol];
  assign midRd = lbMid[procCol];

  column_sorter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uSorter (
    .a  (topRd),
    .b  (midRd),
    .c  (pix_data),
    .hi (sortHi),
    .mid(sortMid),
    .lo (sortLo)
  );

  // Position tracking: the row counter saturates at 2 because it only has to
  // tell whether both line buffers hold real data for this frame.
  always_comb begin
    colD = procCol;
    rowD = procRow;
    if (pix_valid) begin
      if (procCol == LAST_COL) begin
        colD = '0;
        if (procRow != ROW_FULL) begin
          rowD = procRow + 2'd1;
        end
      end else begin
        colD = procCol + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    winValidD = pix_valid && (procRow == ROW_FULL) && (procCol >= ADDR_WIDTH'(2));
  end

  // Line buffers are plain RAM with no reset; stale contents from an earlier
  // frame are masked by the row gating on win_valid.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lbTop[procCol] <= midRd;
      lbMid[procCol] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colQ      <= '0;
      rowQ      <= '0;
      c3hQ      <= '0;
      c3mQ      <= '0;
      c3lQ      <= '0;
      c2hQ      <= '0;
      c2mQ      <= '0;
      c2lQ      <= '0;
      c1hQ      <= '0;
      c1mQ      <= '0;
      c1lQ      <= '0;
      winValidQ <= 1'b0;
    end else begin
      colQ      <= colD;
      rowQ      <= rowD;
      winValidQ <= winValidD;
      if (pix_valid) begin
        c1hQ <= c2hQ;
        c1mQ <= c2mQ;
        c1lQ <= c2lQ;
        c2hQ <= c3hQ;
        c2mQ <= c3mQ;
        c2lQ <= c3lQ;
        c3hQ <= sortHi;
        c3mQ <= sortMid;
        c3lQ <= sortLo;
      end
    end
  end

  assign c3h       = c3hQ;
  assign c3m       = c3mQ;
  assign c3l       = c3lQ;
  assign c2h       = c2hQ;
  assign c2m       = c2mQ;
  assign c2l       = c2lQ;
  assign c1h       = c1hQ;
  assign c1m       = c1mQ;
  assign c1l       = c1lQ;
  assign win_valid = winValidQ;

endmodule

// File: tb/tb_median_window.sv
// tb_median_window: directed bench for median_window with a 4-pixel line.
module tb_median_window;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [7:0] c3h, c3m, c3l, c2h, c2m, c2l, c1h, c1m, c1l;
  logic       win_valid;

  int assertCount = 0;
  int failCount   = 0;
  int winCount    = 0;

  median_window #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .c3h        (c3h),
    .c3m        (c3m),
    .c3l        (c3l),
    .c2h        (c2h),
    .c2m        (c2m),
    .c2l        (c2l),
    .c1h        (c1h),
    .c1m        (c1m),
    .c1l        (c1l),
    .win_valid  (win_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one accepted pixel and checks win_valid one edge later.
  task automatic applyStimulus(input logic [7:0] data, input logic fs,
                               input logic expValid, input string tag);
    @(negedge clk);
    pix_data    = data;
    pix_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    if (win_valid === 1'b1) winCount++;
    checkOutput(tag, {79'd0, win_valid}, {79'd0, expValid});
  endtask

  // Idle cycles with pix_valid low; the strobe must stay low throughout.
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput("gap_valid", {79'd0, win_valid}, 80'd0);
    end
  endtask

  function automatic logic [79:0] col1();
    return {56'd0, c1h, c1m, c1l};
  endfunction
  function automatic logic [79:0] col2();
    return {56'd0, c2h, c2m, c2l};
  endfunction
  function automatic logic [79:0] col3();
    return {56'd0, c3h, c3m, c3l};
  endfunction
  function automatic logic [79:0] allOut();
    return {7'd0, c1h, c1m, c1l, c2h, c2m, c2l, c3h, c3m, c3l, win_valid};
  endfunction

  function automatic logic [79:0] hml(input int h, input int m, input int l);
    return {56'd0, 8'(h), 8'(m), 8'(l)};
  endfunction

  initial begin
    logic [7:0] sortRow0 [4];
    logic [7:0] sortRow1 [4];
    logic [7:0] sortRow2 [4];
    logic       ev;
    sortRow0 = '{8'd7, 8'd90, 8'd200, 8'd200};
    sortRow1 = '{8'd90, 8'd200, 8'd7, 8'd7};
    sortRow2 = '{8'd200, 8'd7, 8'd90, 8'd90};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 8'd0;

    // Reset held while pixels are offered.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pix_valid = ~pix_valid;
      pix_data  = 8'(i * 37 + 5);
    end
    #1;
    checkOutput("reset_hold", allOut(), 80'd0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_release", allOut(), 80'd0);

    $display("[TB] ramp frame back-to-back");
    for (int p = 1; p <= 16; p++) begin
      ev = (p == 11) || (p == 12) || (p == 15) || (p == 16);
      applyStimulus(8'(p), p == 1, ev, $sformatf("ramp_valid_p%0d", p));
      if (p == 11) begin
        checkOutput("ramp11_c1", col1(), hml(9, 5, 1));
        checkOutput("ramp11_c2", col2(), hml(10, 6, 2));
        checkOutput("ramp11_c3", col3(), hml(11, 7, 3));
      end
      if (p == 12) checkOutput("ramp12_c3", col3(), hml(12, 8, 4));
      if (p == 15) begin
        checkOutput("ramp15_c1", col1(), hml(13, 9, 5));
        checkOutput("ramp15_c3", col3(), hml(15, 11, 7));
      end
      if (p == 16) checkOutput("ramp16_c2", col2(), hml(15, 11, 7));
    end

    $display("[TB] sort permutations");
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        pix_data = (r == 0) ? sortRow0[c] : (r == 1) ? sortRow1[c] : sortRow2[c];
        applyStimulus(pix_data, (r == 0) && (c == 0), (r == 2) && (c >= 2),
                      $sformatf("sort_valid_r%0d_c%0d", r, c));
        if (r == 2 && c == 2) begin
          checkOutput("sort_c1", col1(), hml(200, 90, 7));
          checkOutput("sort_c2", col2(), hml(200, 90, 7));
          checkOutput("sort_c3", col3(), hml(200, 90, 7));
        end
      end
    end

    $display("[TB] ramp frame with 3-cycle stalls");
    for (int p = 1; p <= 16; p++) begin
      ev = (p == 11) || (p == 12) || (p == 15) || (p == 16);
      applyStimulus(8'(p), p == 1, ev, $sformatf("stall_valid_p%0d", p));
      if (p == 11) checkOutput("stall11_c1", col1(), hml(9, 5, 1));
      idleCycles(3);
      if (p == 11) checkOutput("stall11_hold_c3", col3(), hml(11, 7, 3));
      if (p == 16) begin
        checkOutput("stall16_c1", col1(), hml(14, 10, 6));
        checkOutput("stall16_c3", col3(), hml(16, 12, 8));
      end
    end

    $display("[TB] frame_start with pixel 7");
    for (int p = 1; p <= 18; p++) begin
      ev = (p == 17) || (p == 18);
      applyStimulus(8'(p), (p == 1) || (p == 7), ev, $sformatf("fs_valid_p%0d", p));
      if (p == 17) begin
        checkOutput("fs17_c1", col1(), hml(15, 11, 7));
        checkOutput("fs17_c2", col2(), hml(16, 12, 8));
        checkOutput("fs17_c3", col3(), hml(17, 13, 9));
      end
    end

    $display("[TB] six-line frame saturation");
    winCount = 0;
    for (int p = 1; p <= 24; p++) begin
      ev = (((p - 1) / 4) >= 2) && (((p - 1) % 4) >= 2);
      applyStimulus(8'(p), p == 1, ev, $sformatf("sat_valid_p%0d", p));
      checkOutput("sat_row_limit", {79'd0, dut.rowQ <= 2'd2}, 80'd1);
    end
    checkOutput("sat_win_count", 80'(winCount), 80'd8);
    checkOutput("sat24_c3", col3(), hml(24, 20, 16));

    $display("[TB] reset mid-frame");
    for (int p = 1; p <= 5; p++) begin
      applyStimulus(8'(p + 100), p == 1, 1'b0, "midrst_pre");
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_clear", allOut(), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 1; p <= 12; p++) begin
      ev = (p == 11) || (p == 12);
      applyStimulus(8'(p), 1'b0, ev, $sformatf("midrst_valid_p%0d", p));
      if (p == 11) checkOutput("midrst11_c3", col3(), hml(11, 7, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
